// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller.
// Contents:
//   - light encodings for one signal head (RED/YEL/GRN)
//   - the phase FSM state enum
//   - BCD limit constants for the time-of-day clock
//   - bcd_inc: increment a two-digit BCD value (caller handles wrap)
//   - is_peak: peak-window decode from a BCD hour and the AM/PM flag
package tlc_pkg;

  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b10;

  typedef enum logic [2:0] {
    S_MAIN_GREEN   = 3'd0,
    S_MAIN_YELLOW  = 3'd1,
    S_SIDE1_GREEN  = 3'd2,
    S_SIDE1_YELLOW = 3'd3,
    S_SIDE2_GREEN  = 3'd4,
    S_SIDE2_YELLOW = 3'd5
  } tlc_state_e;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;  // last second / minute value
  localparam logic [7:0] BCD_HR_TOP = 8'h12;  // hour that wraps to 01
  localparam logic [7:0] BCD_HR_PM  = 8'h11;  // hour whose increment flips AM/PM
  localparam logic [7:0] BCD_HR_ONE = 8'h01;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Peak windows: 08-10 AM and 05-07 PM (hour-granular).
  function automatic logic is_peak(input logic [7:0] hh, input logic pm);
    logic r;
    if (!pm) r = (hh == 8'h08) || (hh == 8'h09) || (hh == 8'h10);
    else     r = (hh == 8'h05) || (hh == 8'h06) || (hh == 8'h07);
    return r;
  endfunction

endpackage

// File: rtl/tlc_rtc.sv
// Time base for the traffic-light controller.
// Generates the one-second tick from clk/ena, keeps a 12-hour BCD
// time of day and decodes the peak-hour flag from the registered hour.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   ena             - global enable; 0 freezes divider and time
//   tick            - one-cycle pulse per second (combinational)
//   hh, mm, ss, pm  - registered BCD time and AM/PM flag
//   peak            - combinational peak-window flag
module tlc_rtc #(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [7:0]  INIT_HH  = 8'h12,
  parameter logic [7:0]  INIT_MM  = 8'h00,
  parameter logic [7:0]  INIT_SS  = 8'h00,
  parameter logic        INIT_PM  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic       tick,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       peak
);
  import tlc_pkg::*;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic             pm_q, pm_d;

  // Divider: tick fires on the enabled cycle where the count is at its last value.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (ena) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Ripple carry ss -> mm -> hh; pm flips only on the 11 -> 12 step.
  always_comb begin
    ss_d = ss_q;
    mm_d = mm_q;
    hh_d = hh_q;
    pm_d = pm_q;
    if (tick) begin
      if (ss_q == BCD_MAX_MS) begin
        ss_d = 8'h00;
        if (mm_q == BCD_MAX_MS) begin
          mm_d = 8'h00;
          if (hh_q == BCD_HR_TOP) begin
            hh_d = BCD_HR_ONE;
          end else begin
            hh_d = bcd_inc(hh_q);
            if (hh_q == BCD_HR_PM) pm_d = ~pm_q;
          end
        end else begin
          mm_d = bcd_inc(mm_q);
        end
      end else begin
        ss_d = bcd_inc(ss_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      hh_q  <= INIT_HH;
      mm_q  <= INIT_MM;
      ss_q  <= INIT_SS;
      pm_q  <= INIT_PM;
    end else begin
      div_q <= div_d;
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
      pm_q  <= pm_d;
    end
  end

  assign hh   = hh_q;
  assign mm   = mm_q;
  assign ss   = ss_q;
  assign pm   = pm_q;
  assign peak = is_peak(hh_q, pm_q);

endmodule

// File: rtl/tlc_top.sv
// Traffic-light controller for one intersection: main road (TL1/TL2)
// plus two sensor-requested side approaches (TL3/TL4, TL5/TL6).
// Ports:
//   clk, reset          - clock, synchronous active-high reset (beats ena)
//   ena                 - global enable; 0 freezes time and phases
//   sensor1, sensor2    - vehicle present on side approach 1 / 2
//   TL1..TL6            - registered light states (00 red, 01 yellow, 10 green)
//   peak, pm, hh, mm, ss - time of day and peak flag from the time base
// Phase timing: entering a phase loads timer = duration-1; each tick
// decrements a nonzero timer; a tick seen with timer==0 applies the exit
// rule, so a phase lasts exactly its duration in ticks.
module tlc_top #(
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned T_MAIN      = 10,
  parameter int unsigned T_MAIN_PEAK = 20,
  parameter int unsigned T_SIDE      = 5,
  parameter int unsigned T_SIDE_PEAK = 3,
  parameter int unsigned T_YEL       = 2,
  parameter logic [7:0]  INIT_HH     = 8'h12,
  parameter logic [7:0]  INIT_MM     = 8'h00,
  parameter logic [7:0]  INIT_SS     = 8'h00,
  parameter logic        INIT_PM     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       sensor1,
  input  logic       sensor2,
  output logic [1:0] TL1,
  output logic [1:0] TL2,
  output logic [1:0] TL3,
  output logic [1:0] TL4,
  output logic [1:0] TL5,
  output logic [1:0] TL6,
  output logic       peak,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);
  import tlc_pkg::*;

  localparam logic [7:0] T_MAIN_M1      = 8'(T_MAIN - 1);
  localparam logic [7:0] T_MAIN_PEAK_M1 = 8'(T_MAIN_PEAK - 1);
  localparam logic [7:0] T_SIDE_M1      = 8'(T_SIDE - 1);
  localparam logic [7:0] T_SIDE_PEAK_M1 = 8'(T_SIDE_PEAK - 1);
  localparam logic [7:0] T_YEL_M1       = 8'(T_YEL - 1);
  localparam logic       INIT_PEAK      = is_peak(INIT_HH, INIT_PM);
  localparam logic [7:0] TIMER_RST      = INIT_PEAK ? T_MAIN_PEAK_M1 : T_MAIN_M1;

  logic       tick;
  tlc_state_e state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       req1_q, req1_d, req2_q, req2_d;
  logic [1:0] main_q, main_d, side1_q, side1_d, side2_q, side2_d;
  logic [7:0] main_dur, side_dur;

  tlc_rtc #(
    .TICK_DIV (TICK_DIV),
    .INIT_HH  (INIT_HH),
    .INIT_MM  (INIT_MM),
    .INIT_SS  (INIT_SS),
    .INIT_PM  (INIT_PM)
  ) u_rtc (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .tick  (tick),
    .hh    (hh),
    .mm    (mm),
    .ss    (ss),
    .pm    (pm),
    .peak  (peak)
  );

  // Durations are taken from the peak flag seen on the entering tick.
  assign main_dur = peak ? T_MAIN_PEAK_M1 : T_MAIN_M1;
  assign side_dur = peak ? T_SIDE_PEAK_M1 : T_SIDE_M1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (tick) begin
      if (timer_q != 8'd0) begin
        timer_d = timer_q - 8'd1;
      end else begin
        case (state_q)
          S_MAIN_GREEN: begin
            // Main green is held indefinitely until a side request exists.
            if (req1_q || req2_q) begin
              state_d = S_MAIN_YELLOW;
              timer_d = T_YEL_M1;
            end
          end
          S_MAIN_YELLOW: begin
            state_d = req1_q ? S_SIDE1_GREEN : S_SIDE2_GREEN;
            timer_d = side_dur;
          end
          S_SIDE1_GREEN: begin
            state_d = S_SIDE1_YELLOW;
            timer_d = T_YEL_M1;
          end
          S_SIDE1_YELLOW: begin
            if (req2_q) begin
              state_d = S_SIDE2_GREEN;
              timer_d = side_dur;
            end else begin
              state_d = S_MAIN_GREEN;
              timer_d = main_dur;
            end
          end
          S_SIDE2_GREEN: begin
            state_d = S_SIDE2_YELLOW;
            timer_d = T_YEL_M1;
          end
          default: begin
            state_d = S_MAIN_GREEN;
            timer_d = main_dur;
          end
        endcase
      end
    end
  end

  // Requests latch regardless of ena; a sensor set wins over the entry clear.
  always_comb begin
    req1_d = sensor1 | (req1_q & ~((state_d == S_SIDE1_GREEN) && (state_q != S_SIDE1_GREEN)));
    req2_d = sensor2 | (req2_q & ~((state_d == S_SIDE2_GREEN) && (state_q != S_SIDE2_GREEN)));
  end

  // Lights decode the next state so they change on the same edge as the state.
  always_comb begin
    main_d  = LIGHT_RED;
    side1_d = LIGHT_RED;
    side2_d = LIGHT_RED;
    case (state_d)
      S_MAIN_GREEN:   main_d  = LIGHT_GRN;
      S_MAIN_YELLOW:  main_d  = LIGHT_YEL;
      S_SIDE1_GREEN:  side1_d = LIGHT_GRN;
      S_SIDE1_YELLOW: side1_d = LIGHT_YEL;
      S_SIDE2_GREEN:  side2_d = LIGHT_GRN;
      default:        side2_d = LIGHT_YEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_MAIN_GREEN;
      timer_q <= TIMER_RST;
      req1_q  <= 1'b0;
      req2_q  <= 1'b0;
      main_q  <= LIGHT_GRN;
      side1_q <= LIGHT_RED;
      side2_q <= LIGHT_RED;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req1_q  <= req1_d;
      req2_q  <= req2_d;
      main_q  <= main_d;
      side1_q <= side1_d;
      side2_q <= side2_d;
    end
  end

  assign TL1 = main_q;
  assign TL2 = main_q;
  assign TL3 = side1_q;
  assign TL4 = side1_q;
  assign TL5 = side2_q;
  assign TL6 = side2_q;

endmodule

// File: tb/tb_tlc_top.sv
// Directed bench for tlc_top. Four instances share clk/reset/ena:
//   u_dut - default parameters, sensors driven by the bench
//   u_a   - starts 11:59:59 AM (AM->PM rollover)
//   u_b   - starts 12:59:59 PM (12->01 wrap, pm unchanged)
//   u_c   - starts 07:59:59 AM with both sensors tied high (peak timing)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tlc_top;

  logic clk;
  logic reset;
  logic ena;
  logic s1;
  logic s2;

  logic [5:0][1:0] tl_d, tl_a, tl_b, tl_c;
  logic            peak_d, peak_a, peak_b, peak_c;
  logic            pm_d, pm_a, pm_b, pm_c;
  logic [7:0]      hh_d, hh_a, hh_b, hh_c;
  logic [7:0]      mm_d, mm_a, mm_b, mm_c;
  logic [7:0]      ss_d, ss_a, ss_b, ss_c;

  int n_assert;
  int n_fail;

  tlc_top u_dut (
    .clk(clk), .reset(reset), .ena(ena), .sensor1(s1), .sensor2(s2),
    .TL1(tl_d[5]), .TL2(tl_d[4]), .TL3(tl_d[3]), .TL4(tl_d[2]), .TL5(tl_d[1]), .TL6(tl_d[0]),
    .peak(peak_d), .pm(pm_d), .hh(hh_d), .mm(mm_d), .ss(ss_d)
  );

  tlc_top #(.INIT_HH(8'h11), .INIT_MM(8'h59), .INIT_SS(8'h59), .INIT_PM(1'b0)) u_a (
    .clk(clk), .reset(reset), .ena(ena), .sensor1(1'b0), .sensor2(1'b0),
    .TL1(tl_a[5]), .TL2(tl_a[4]), .TL3(tl_a[3]), .TL4(tl_a[2]), .TL5(tl_a[1]), .TL6(tl_a[0]),
    .peak(peak_a), .pm(pm_a), .hh(hh_a), .mm(mm_a), .ss(ss_a)
  );

  tlc_top #(.INIT_HH(8'h12), .INIT_MM(8'h59), .INIT_SS(8'h59), .INIT_PM(1'b1)) u_b (
    .clk(clk), .reset(reset), .ena(ena), .sensor1(1'b0), .sensor2(1'b0),
    .TL1(tl_b[5]), .TL2(tl_b[4]), .TL3(tl_b[3]), .TL4(tl_b[2]), .TL5(tl_b[1]), .TL6(tl_b[0]),
    .peak(peak_b), .pm(pm_b), .hh(hh_b), .mm(mm_b), .ss(ss_b)
  );

  tlc_top #(.INIT_HH(8'h07), .INIT_MM(8'h59), .INIT_SS(8'h59), .INIT_PM(1'b0)) u_c (
    .clk(clk), .reset(reset), .ena(ena), .sensor1(1'b1), .sensor2(1'b1),
    .TL1(tl_c[5]), .TL2(tl_c[4]), .TL3(tl_c[3]), .TL4(tl_c[2]), .TL5(tl_c[1]), .TL6(tl_c[0]),
    .peak(peak_c), .pm(pm_c), .hh(hh_c), .mm(mm_c), .ss(ss_c)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase index -> expected {TL1..TL6}
  // 0 main green, 1 main yellow, 2 side1 green, 3 side1 yellow, 4 side2 green, 5 side2 yellow
  function automatic logic [11:0] lights(input int ph);
    logic [11:0] r;
    case (ph)
      0:       r = 12'b10_10_00_00_00_00;
      1:       r = 12'b01_01_00_00_00_00;
      2:       r = 12'b00_00_10_10_00_00;
      3:       r = 12'b00_00_01_01_00_00;
      4:       r = 12'b00_00_00_00_10_10;
      default: r = 12'b00_00_00_00_01_01;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int non_red(input logic [11:0] t);
    return int'(t[11:10] != 2'b00) + int'(t[7:6] != 2'b00) + int'(t[3:2] != 2'b00);
  endfunction

  // Hand-derived phase schedules, k = ticks since reset release.
  // Sensor1 only, first request well before main green expires.
  function automatic int ph_side1_only(input int k);
    if (k <= 9)  return 0;
    if (k <= 11) return 1;
    if (k <= 16) return 2;
    if (k <= 18) return 3;
    return 0;
  endfunction

  // Both sensors held, off-peak durations.
  function automatic int ph_both(input int k);
    if (k <= 9)  return 0;
    if (k <= 11) return 1;
    if (k <= 16) return 2;
    if (k <= 18) return 3;
    if (k <= 23) return 4;
    if (k <= 25) return 5;
    if (k <= 35) return 0;
    if (k <= 37) return 1;
    if (k <= 42) return 2;
    if (k <= 44) return 3;
    return 4;
  endfunction

  // Both sensors held, peak from the first tick onwards (first main green off-peak).
  function automatic int ph_peak(input int k);
    if (k <= 9)  return 0;
    if (k <= 11) return 1;
    if (k <= 14) return 2;
    if (k <= 16) return 3;
    if (k <= 19) return 4;
    if (k <= 21) return 5;
    if (k <= 41) return 0;
    if (k <= 43) return 1;
    return 2;
  endfunction

  // Driver tasks
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ena   = 1'b1;
    s1    = 1'b0;
    s2    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    ena   = 1'b1;
    s1    = 1'b0;
    s2    = 1'b0;

    // Reset state, idle counting, clock rollovers
    do_reset();
    check("rst_tl",   tl_d,   lights(0));
    check("rst_hh",   hh_d,   8'h12);
    check("rst_mm",   mm_d,   8'h00);
    check("rst_ss",   ss_d,   8'h00);
    check("rst_pm",   pm_d,   1'b0);
    check("rst_peak", peak_d, 1'b0);
    check("rst_a_time", {hh_a, mm_a, ss_a}, {8'h11, 8'h59, 8'h59});
    check("rst_b_time", {hh_b, mm_b, ss_b}, {8'h12, 8'h59, 8'h59});
    check("rst_c_peak", peak_c, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      check("idle_tl", tl_d, lights(0));
      check("idle_ss", ss_d, to_bcd(k));
      if (k == 1) begin
        check("roll_a_time", {hh_a, mm_a, ss_a}, {8'h12, 8'h00, 8'h00});
        check("roll_a_pm",   pm_a,   1'b1);
        check("roll_a_peak", peak_a, 1'b0);
        check("roll_b_time", {hh_b, mm_b, ss_b}, {8'h01, 8'h00, 8'h00});
        check("roll_b_pm",   pm_b,   1'b1);
        check("roll_c_hh",   hh_c,   8'h08);
        check("roll_c_peak", peak_c, 1'b1);
      end
    end
    check("idle_hh",   hh_d,   8'h12);
    check("idle_mm",   mm_d,   8'h00);
    check("idle_pm",   pm_d,   1'b0);
    check("idle_peak", peak_d, 1'b0);

    // Single sensor1 pulse before the third tick
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      check("s1_tl", tl_d, lights(ph_side1_only(k)));
      if (k == 2) s1 = 1'b1;
      if (k == 3) s1 = 1'b0;
    end

    // Both sensors held; u_c runs the same schedule with peak durations
    do_reset();
    s1 = 1'b1;
    s2 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      check("both_tl",     tl_d, lights(ph_both(k)));
      check("both_safe",   non_red(tl_d) <= 1, 1'b1);
      check("peak_tl",     tl_c, lights(ph_peak(k)));
      check("peak_safe",   non_red(tl_c) <= 1, 1'b1);
    end
    s1 = 1'b0;
    s2 = 1'b0;

    // Freeze mid side1 green, request side2 while frozen, then reset mid-phase
    do_reset();
    s1 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) s1 = 1'b0;
    end
    check("pre_frz_tl", tl_d, lights(2));
    check("pre_frz_ss", ss_d, 8'h13);
    ena = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check("frz_tl", tl_d, lights(2));
      check("frz_ss", ss_d, 8'h13);
      check("frz_hh", hh_d, 8'h12);
      if (j == 3) s2 = 1'b1;
      if (j == 4) s2 = 1'b0;
    end
    ena = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("resume_tl", tl_d, lights(j <= 3 ? 2 : (j <= 5 ? 3 : 4)));
      check("resume_ss", ss_d, to_bcd(13 + j));
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tl", tl_d, lights(0));
    check("midrst_time", {hh_d, mm_d, ss_d}, {8'h12, 8'h00, 8'h00});
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tl", tl_d, lights(0));
    check("post_rst_ss", ss_d, 8'h01);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
